// File: rtl/fp16_adder.sv
// Brain-float (1/8/7) adder with round-to-nearest-even and flush-to-zero for subnormals.
// Latency 1 cycle, fully pipelined: every in_valid beat is accepted, there is no backpressure.
module fp16_adder #(
  parameter int EXP_SIZE      = 8,
  parameter int MANTISSA_SIZE = 7,
  parameter int SIGN_SIZE     = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  input  logic [SIGN_SIZE+EXP_SIZE+MANTISSA_SIZE-1:0] a,
  input  logic [SIGN_SIZE+EXP_SIZE+MANTISSA_SIZE-1:0] b,
  output logic                                        out_valid,
  output logic [SIGN_SIZE+EXP_SIZE+MANTISSA_SIZE-1:0] sum,
  output logic                                        sum_zero,
  output logic                                        overflow
);

  localparam int W    = SIGN_SIZE + EXP_SIZE + MANTISSA_SIZE;
  localparam int E    = EXP_SIZE;
  localparam int M    = MANTISSA_SIZE;
  localparam int SW   = M + 4;
  localparam int LZW  = $clog2(SW);
  localparam int XW   = E + 2;
  localparam int EMAX = (1 << E) - 1;

  localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

  logic         sa, sb;
  logic [E-1:0] ea, eb;
  logic [M-1:0] ma, mb;

  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == E'(EMAX)) && (ma == '0);
  assign b_inf  = (eb == E'(EMAX)) && (mb == '0);
  assign a_nan  = (ea == E'(EMAX)) && (ma != '0);
  assign b_nan  = (eb == E'(EMAX)) && (mb != '0);

  // Order by magnitude so the subtraction below never goes negative.
  logic         a_ge;
  logic         sl;
  logic [E-1:0] el, es, diff;
  logic [M-1:0] ml, ms;

  assign a_ge = {ea, ma} >= {eb, mb};
  assign sl   = a_ge ? sa : sb;
  assign el   = a_ge ? ea : eb;
  assign ml   = a_ge ? ma : mb;
  assign es   = a_ge ? eb : ea;
  assign ms   = a_ge ? mb : ma;
  assign diff = el - es;

  logic [SW-1:0] sig_l, sig_s, sig_sh;
  logic          lost;

  assign sig_l = {1'b1, ml, 3'b000};
  assign sig_s = {1'b1, ms, 3'b000};

  always_comb begin
    sig_sh = '0;
    lost   = 1'b0;
    if (diff >= E'(SW)) begin
      sig_sh[0] = 1'b1;
    end else begin
      sig_sh    = sig_s >> diff;
      lost      = |(sig_s & ((SW'(1) << diff) - SW'(1)));
      sig_sh[0] = sig_sh[0] | lost;
    end
  end

  logic [SW:0] raw;

  assign raw = (sa == sb) ? ({1'b0, sig_l} + {1'b0, sig_sh})
                          : ({1'b0, sig_l} - {1'b0, sig_sh});

  logic [LZW-1:0] lz;
  logic           lz_found;

  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!lz_found && raw[i]) begin
        lz       = LZW'(SW - 1 - i);
        lz_found = 1'b1;
      end
    end
  end

  logic [SW-1:0] norm;
  logic [XW-1:0] exp_n;

  always_comb begin
    if (raw[SW]) begin
      norm    = raw[SW:1];
      norm[0] = raw[1] | raw[0];
      exp_n   = XW'(el) + XW'(1);
    end else begin
      norm  = raw[SW-1:0] << lz;
      exp_n = XW'(el) - XW'(lz);
    end
  end

  logic          round_up;
  logic [M:0]    mant_r;
  logic [XW-1:0] exp_r;

  // Guard set and (round | sticky | odd lsb) rounds up: nearest, ties to even.
  assign round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign mant_r   = {1'b0, norm[SW-2:3]} + (M+1)'(round_up);
  assign exp_r    = exp_n + XW'(mant_r[M]);

  logic [W-1:0] res;
  logic         res_zero, res_ovf;

  always_comb begin
    res      = '0;
    res_zero = 1'b0;
    res_ovf  = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      res = QNAN;
    end else if (a_inf) begin
      res = {sa, {E{1'b1}}, {M{1'b0}}};
    end else if (b_inf) begin
      res = {sb, {E{1'b1}}, {M{1'b0}}};
    end else if (a_zero && b_zero) begin
      res      = {sa & sb, {(W-1){1'b0}}};
      res_zero = 1'b1;
    end else if (a_zero) begin
      res = b;
    end else if (b_zero) begin
      res = a;
    end else if (raw == '0) begin
      res_zero = 1'b1;
    end else if (exp_n[XW-1] || (exp_n == '0)) begin
      res      = {sl, {(W-1){1'b0}}};
      res_zero = 1'b1;
    end else if (exp_r >= XW'(EMAX)) begin
      res     = {sl, {E{1'b1}}, {M{1'b0}}};
      res_ovf = 1'b1;
    end else begin
      res = {sl, exp_r[E-1:0], mant_r[M-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      sum_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum      <= res;
        sum_zero <= res_zero;
        overflow <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fp16_adder.sv
// Directed-vector bench for fp16_adder: each step drives one beat and checks the registered result.
module tb_fp16_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [15:0] sum;
  logic        sum_zero;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  fp16_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .sum       (sum),
    .sum_zero  (sum_zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the following falling edge sees the registered result.
  task automatic step(input logic [15:0] xa, input logic [15:0] xb, input logic v);
    a        = xa;
    b        = xb;
    in_valid = v;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic ev, input logic [15:0] es,
                       input logic ez, input logic eo);
    logic [18:0] obs;
    logic [18:0] req;
    obs = {out_valid, sum_zero, overflow, sum};
    req = {ev, ez, eo, es};
    n_cmp++;
    assert (obs === req)
    else begin
      n_bad++;
      $error("FAIL %s: observed valid=%b zero=%b ovf=%b sum=%h, expected valid=%b zero=%b ovf=%b sum=%h",
             tag, obs[18], obs[17], obs[16], obs[15:0], req[18], req[17], req[16], req[15:0]);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(negedge clk);
    check("reset_state", 1'b0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;

    step(16'h4140, 16'h3F80, 1'b1); check("12_plus_1",        1'b1, 16'h4150, 1'b0, 1'b0);
    step(16'h3F80, 16'h4140, 1'b1); check("1_plus_12",        1'b1, 16'h4150, 1'b0, 1'b0);
    step(16'h3F80, 16'hBF80, 1'b1); check("cancel",           1'b1, 16'h0000, 1'b1, 1'b0);
    step(16'hBF80, 16'h3F80, 1'b1); check("cancel_swap",      1'b1, 16'h0000, 1'b1, 1'b0);
    step(16'h7F7F, 16'h7F7F, 1'b1); check("overflow_pos",     1'b1, 16'h7F80, 1'b0, 1'b1);
    step(16'hFF7F, 16'hFF7F, 1'b1); check("overflow_neg",     1'b1, 16'hFF80, 1'b0, 1'b1);
    step(16'h7F80, 16'hFF80, 1'b1); check("inf_minus_inf",    1'b1, 16'h7FC0, 1'b0, 1'b0);
    step(16'h7FC1, 16'h3F80, 1'b1); check("nan_in",           1'b1, 16'h7FC0, 1'b0, 1'b0);
    step(16'hFF80, 16'h4000, 1'b1); check("neg_inf_plus_2",   1'b1, 16'hFF80, 1'b0, 1'b0);
    step(16'h0001, 16'h3F80, 1'b1); check("subnormal_flush",  1'b1, 16'h3F80, 1'b0, 1'b0);
    step(16'h3F80, 16'h3B80, 1'b1); check("tie_down_even",    1'b1, 16'h3F80, 1'b0, 1'b0);
    step(16'h3B80, 16'h3F80, 1'b1); check("tie_down_swap",    1'b1, 16'h3F80, 1'b0, 1'b0);
    step(16'h3F81, 16'h3B80, 1'b1); check("tie_up_even",      1'b1, 16'h3F82, 1'b0, 1'b0);
    step(16'h3FFF, 16'h3B80, 1'b1); check("round_carry_exp",  1'b1, 16'h4000, 1'b0, 1'b0);
    step(16'h3F80, 16'hB300, 1'b1); check("sub_sticky",       1'b1, 16'h3F80, 1'b0, 1'b0);
    step(16'h4000, 16'hBFC0, 1'b1); check("2_minus_1p5",      1'b1, 16'h3F00, 1'b0, 1'b0);
    step(16'h8000, 16'h8000, 1'b1); check("negzero_negzero",  1'b1, 16'h8000, 1'b1, 1'b0);
    step(16'h0000, 16'h8000, 1'b1); check("mixed_zeros",      1'b1, 16'h0000, 1'b1, 1'b0);
    step(16'h80C0, 16'h0080, 1'b1); check("underflow_flush",  1'b1, 16'h8000, 1'b1, 1'b0);

    rst = 1'b1;
    step(16'h4140, 16'h3F80, 1'b1); check("reset_over_valid", 1'b0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;

    step(16'h4140, 16'h3F80, 1'b1); check("b2b_beat0", 1'b1, 16'h4150, 1'b0, 1'b0);
    step(16'h3F80, 16'h3F80, 1'b1); check("b2b_beat1", 1'b1, 16'h4000, 1'b0, 1'b0);
    step(16'h7F7F, 16'h7F7F, 1'b1); check("b2b_beat2", 1'b1, 16'h7F80, 1'b0, 1'b1);
    step(16'h3F80, 16'hBF80, 1'b0); check("idle_hold", 1'b0, 16'h7F80, 1'b0, 1'b1);
    step(16'h0000, 16'h0000, 1'b0); check("idle_hold2", 1'b0, 16'h7F80, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
